// File: rtl/uart_rx_fifo_sched_if.sv
// Byte-stream interface around the UART RX FIFO scheduler.
// Carries the receive-side capture strobe (rx_done/rx_byte/rx_stop) and the
// show-ahead valid/ready read port (m_data/m_valid/m_ready).
// master: the FIFO scheduler, which sources the read stream.
// slave : the surrounding environment (RX controller plus consumer).
interface uart_rx_fifo_sched_if;
  logic       rx_done;
  logic [7:0] rx_byte;
  logic       rx_stop;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (
    input  rx_done, rx_byte, rx_stop, m_ready,
    output m_data, m_valid
  );

  modport slave (
    output rx_done, rx_byte, rx_stop, m_ready,
    input  m_data, m_valid
  );
endinterface

// File: rtl/uart_rx_fifo_sched.sv
// UART RX FIFO scheduler.
// Captures each byte on the rx_done pulse, checks its stop bit, and commits good
// bytes to a circular FIFO that is read through a show-ahead valid/ready port.
// Bytes with a bad stop bit set frame_err; bytes arriving while full set overflow.
// Both flags are sticky until clr_err, and a new error outranks a same-cycle clear.
// Optional feature macro: RX_TIMEOUT_EN enables the idle-line timeout pulse on
// rx_timeout; without it rx_timeout is tied low and no counter is built.
module uart_rx_fifo_sched #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BR           = 9600,
  parameter int DEPTH_LOG2   = 4,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                    clk_r,
  input  logic                    rst,
  uart_rx_fifo_sched_if.master    bus,
  output logic [DEPTH_LOG2:0]     fifo_count,
  output logic                    overflow,
  output logic                    frame_err,
  input  logic                    clr_err,
  output logic                    rx_timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_CHECK  = 2'd1;
  localparam logic [1:0] W_COMMIT = 2'd2;
  localparam logic [1:0] W_DROP   = 2'd3;

  logic [1:0]            state;
  logic [7:0]            hold_byte;
  logic                  hold_stop;
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [7:0]            mem [DEPTH];
  logic                  full;
  logic                  empty;
  logic                  pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign pop        = !empty && bus.m_ready;
  assign fifo_count = wr_ptr - rd_ptr;

  // Show-ahead read port; data is forced to zero while nothing is stored.
  assign bus.m_valid = !empty;
  assign bus.m_data  = empty ? 8'h00 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Write FSM: capture, then decide commit or drop using the pre-pop full flag.
  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      state     <= W_IDLE;
      hold_byte <= 8'h00;
      hold_stop <= 1'b0;
    end else begin
      case (state)
        W_IDLE: begin
          if (bus.rx_done) begin
            hold_byte <= bus.rx_byte;
            hold_stop <= bus.rx_stop;
            state     <= W_CHECK;
          end
        end
        W_CHECK:  state <= (!hold_stop || full) ? W_DROP : W_COMMIT;
        W_COMMIT: state <= W_IDLE;
        default:  state <= W_IDLE;
      endcase
    end
  end

  // Pointer update; commit and pop may both happen in one cycle.
  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (state == W_COMMIT) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)               rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array is left unreset so it can map onto plain RAM.
  always_ff @(posedge clk_r) begin
    if (state == W_COMMIT) mem[wr_ptr[DEPTH_LOG2-1:0]] <= hold_byte;
  end

  // Sticky error flags; setting takes priority over a same-cycle clear.
  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (state == W_CHECK && !hold_stop)      frame_err <= 1'b1;
      else if (clr_err)                        frame_err <= 1'b0;
      if (state == W_CHECK && hold_stop && full) overflow <= 1'b1;
      else if (clr_err)                        overflow  <= 1'b0;
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int BIT_CYC  = CLK_FREQ / BR;
  localparam int TO_LIMIT = BIT_CYC * TIMEOUT_BITS;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
  localparam logic [TO_W-1:0] TO_HOLD = TO_W'(TO_LIMIT);

  logic [TO_W-1:0] to_cnt;

  // Idle counter: runs while data waits unread, parks past the pulse value.
  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (bus.rx_done || empty) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_HOLD) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign rx_timeout = !empty && (to_cnt == TO_LAST);
`else
  assign rx_timeout = 1'b0;
`endif

endmodule
